divclk_monitor: RTL and testbench

DIVCLK_MONITOR -- requirements
Module: divclk_monitor

---
 rtl/clk_div_pkg.sv | 13 +
 rtl/bit_sync.sv | 21 ++
 rtl/divclk_monitor.sv | 110 +++++++++++
 tb/tb_divclk_monitor.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and defaults for the divided-clock monitor.
// Holds the FSM state encoding and the default stall timeout.
package clk_div_pkg;

    typedef enum logic [1:0] {
        ACQUIRE = 2'd0,
        LOCKED  = 2'd1,
        STALLED = 2'd2
    } state_t;

    localparam int DEF_TIMEOUT = 500000;

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchronizer bringing an asynchronous single-bit signal into the clk domain.
module bit_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic sync_p0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_p0 <= 1'b0;
            q       <= 1'b0;
        end else begin
            sync_p0 <= d;
            q       <= sync_p0;
        end
    end

endmodule

// File: rtl/divclk_monitor.sv
// Watches a divided clock sampled as data: edge pulses, period measurement,
// edge counting and a lock/stall state machine.
module divclk_monitor
    import clk_div_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int PW      = $clog2(TIMEOUT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clk_in,
    input  logic          en,
    output logic          tick,
    output logic          fall_tick,
    output logic [PW-1:0] period,
    output logic [15:0]   edge_cnt,
    output logic          locked,
    output logic          stall
);

    localparam logic [PW-1:0] TIMEOUT_V = PW'(TIMEOUT);
    localparam logic [PW-1:0] ONE_V     = PW'(1);

    logic          sync_p1;
    logic          hist_p2;
    logic          rise;
    logic          fall;
    logic          timeout;
    logic [PW-1:0] gap_cnt;
    state_t        state;

    bit_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (clk_in),
        .q   (sync_p1)
    );

    // Edge detection: synchronizer output against one cycle of history
    assign rise    = sync_p1 & ~hist_p2;
    assign fall    = ~sync_p1 & hist_p2;
    // An edge in the same cycle as the timeout always wins
    assign timeout = en && (gap_cnt == TIMEOUT_V) && !rise;

    always_ff @(posedge clk) begin
        if (!rst) begin
            hist_p2   <= 1'b0;
            tick      <= 1'b0;
            fall_tick <= 1'b0;
            period    <= '0;
            edge_cnt  <= '0;
            gap_cnt   <= ONE_V;
            state     <= ACQUIRE;
            locked    <= 1'b0;
            stall     <= 1'b0;
        end else begin
            hist_p2   <= sync_p1;
            tick      <= rise;
            fall_tick <= fall;

            if (rise) begin
                gap_cnt <= ONE_V;
            end else if (en && (gap_cnt != TIMEOUT_V)) begin
                gap_cnt <= gap_cnt + ONE_V;
            end

            if (rise && en) begin
                edge_cnt <= edge_cnt + 16'd1;
            end

            // locked/stall are written with the state so they never lag it
            case (state)
                ACQUIRE: begin
                    if (rise) begin
                        state  <= LOCKED;
                        locked <= 1'b1;
                        stall  <= 1'b0;
                    end else if (timeout) begin
                        state  <= STALLED;
                        locked <= 1'b0;
                        stall  <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (rise) begin
                        period <= gap_cnt;
                    end else if (timeout) begin
                        state  <= STALLED;
                        period <= TIMEOUT_V;
                        locked <= 1'b0;
                        stall  <= 1'b1;
                    end
                end
                STALLED: begin
                    if (rise) begin
                        state  <= ACQUIRE;
                        locked <= 1'b0;
                        stall  <= 1'b0;
                    end
                end
                default: begin
                    state  <= ACQUIRE;
                    locked <= 1'b0;
                    stall  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divclk_monitor.sv
// Directed bench for divclk_monitor with TIMEOUT=16: per-cycle vector table
// followed by hand-written multi-cycle sequences.
module tb_divclk_monitor;

    localparam int TIMEOUT = 16;
    localparam int PW      = $clog2(TIMEOUT + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          clk_in;
    logic          en;
    logic          tick;
    logic          fall_tick;
    logic [PW-1:0] period;
    logic [15:0]   edge_cnt;
    logic          locked;
    logic          stall;

    int total  = 0;
    int passed = 0;

    typedef struct {
        logic rst;
        logic ci;
        logic en;
        logic tick;
        logic fall;
        int   period;
        int   ecnt;
        logic locked;
        logic stall;
    } vec_t;

    vec_t vt[18];

    divclk_monitor #(.TIMEOUT(TIMEOUT), .PW(PW)) dut (
        .clk       (clk),
        .rst       (rst),
        .clk_in    (clk_in),
        .en        (en),
        .tick      (tick),
        .fall_tick (fall_tick),
        .period    (period),
        .edge_cnt  (edge_cnt),
        .locked    (locked),
        .stall     (stall)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic chk_all(input string tag, input int t, input int f, input int p,
                           input int e, input int l, input int s);
        chk({tag, "_tick"},   int'(tick),      t);
        chk({tag, "_fall"},   int'(fall_tick), f);
        chk({tag, "_period"}, int'(period),    p);
        chk({tag, "_ecnt"},   int'(edge_cnt),  e);
        chk({tag, "_locked"}, int'(locked),    l);
        chk({tag, "_stall"},  int'(stall),     s);
    endtask

    task automatic do_reset();
        rst    = 1'b0;
        clk_in = 1'b0;
        en     = 1'b1;
        cyc(2);
        rst    = 1'b1;
    endtask

    function automatic vec_t mk(input logic r, input logic c, input logic e,
                                input logic t, input logic f, input int p,
                                input int n, input logic l, input logic s);
        vec_t v;
        v.rst = r; v.ci = c; v.en = e; v.tick = t; v.fall = f;
        v.period = p; v.ecnt = n; v.locked = l; v.stall = s;
        return v;
    endfunction

    initial begin
        int nt;
        int nf;
        int ns;
        int first_tick;

        rst    = 1'b0;
        clk_in = 1'b0;
        en     = 1'b1;

        // rst ci en | tick fall period ecnt locked stall
        vt[0]  = mk(0, 0, 1,  0, 0, 0, 0, 0, 0);
        vt[1]  = mk(0, 0, 1,  0, 0, 0, 0, 0, 0);
        vt[2]  = mk(1, 1, 1,  0, 0, 0, 0, 0, 0);
        vt[3]  = mk(1, 1, 1,  0, 0, 0, 0, 0, 0);
        vt[4]  = mk(1, 1, 1,  1, 0, 0, 1, 1, 0);
        vt[5]  = mk(1, 1, 1,  0, 0, 0, 1, 1, 0);
        vt[6]  = mk(1, 0, 1,  0, 0, 0, 1, 1, 0);
        vt[7]  = mk(1, 0, 1,  0, 0, 0, 1, 1, 0);
        vt[8]  = mk(1, 0, 1,  0, 1, 0, 1, 1, 0);
        vt[9]  = mk(1, 0, 1,  0, 0, 0, 1, 1, 0);
        vt[10] = mk(1, 1, 1,  0, 0, 0, 1, 1, 0);
        vt[11] = mk(1, 1, 1,  0, 0, 0, 1, 1, 0);
        vt[12] = mk(1, 1, 1,  1, 0, 8, 2, 1, 0);
        vt[13] = mk(1, 1, 1,  0, 0, 8, 2, 1, 0);
        vt[14] = mk(1, 0, 1,  0, 0, 8, 2, 1, 0);
        vt[15] = mk(1, 0, 1,  0, 0, 8, 2, 1, 0);
        vt[16] = mk(1, 0, 1,  0, 1, 8, 2, 1, 0);
        vt[17] = mk(1, 0, 1,  0, 0, 8, 2, 1, 0);

        for (int i = 0; i < 18; i++) begin
            rst    = vt[i].rst;
            clk_in = vt[i].ci;
            en     = vt[i].en;
            cyc(1);
            chk_all($sformatf("vec%0d", i), vt[i].tick, vt[i].fall, vt[i].period,
                    vt[i].ecnt, vt[i].locked, vt[i].stall);
        end

        // Square wave of 8 cycles: tick latency, pulse counts, period
        do_reset();
        nt = 0; nf = 0; first_tick = 0;
        for (int p = 0; p < 6; p++) begin
            for (int c = 0; c < 8; c++) begin
                clk_in = (c < 4);
                cyc(1);
                if (tick) begin
                    nt++;
                    if (first_tick == 0) first_tick = p * 8 + c + 1;
                end
                if (fall_tick) nf++;
            end
        end
        chk("sq_first_tick_cycle", first_tick, 3);
        chk("sq_ticks", nt, 6);
        chk("sq_falls", nf, 6);
        chk("sq_period", int'(period), 8);
        chk("sq_locked", int'(locked), 1);
        chk("sq_ecnt", int'(edge_cnt), 6);

        // ACQUIRE -> STALLED with no edge at all
        do_reset();
        cyc(15);
        chk("acq_nostall15", int'(stall), 0);
        cyc(1);
        chk("acq_stall16", int'(stall), 1);
        chk("acq_stall_locked", int'(locked), 0);

        // Static clk_in after lock: stall 16 cycles after the last tick
        do_reset();
        clk_in = 1'b1;
        cyc(3);
        chk("st_tick", int'(tick), 1);
        chk("st_locked", int'(locked), 1);
        chk("st_period_first", int'(period), 0);
        cyc(15);
        chk("st_stall15", int'(stall), 0);
        chk("st_locked15", int'(locked), 1);
        cyc(1);
        chk("st_stall16", int'(stall), 1);
        chk("st_locked16", int'(locked), 0);
        chk("st_period16", int'(period), 16);
        clk_in = 1'b0;
        cyc(4);
        clk_in = 1'b1;
        cyc(3);
        chk("st_re_tick", int'(tick), 1);
        chk("st_re_stall", int'(stall), 0);
        chk("st_re_locked", int'(locked), 0);
        chk("st_re_period", int'(period), 16);
        clk_in = 1'b0;
        cyc(5);
        clk_in = 1'b1;
        cyc(3);
        chk("st_relock_tick", int'(tick), 1);
        chk("st_relock_locked", int'(locked), 1);
        chk("st_relock_period", int'(period), 16);

        // Rise exactly when gap_cnt reaches TIMEOUT: edge wins
        do_reset();
        clk_in = 1'b1;
        cyc(3);
        clk_in = 1'b0;
        cyc(13);
        clk_in = 1'b1;
        cyc(2);
        chk("race_pre_tick", int'(tick), 0);
        chk("race_pre_stall", int'(stall), 0);
        cyc(1);
        chk("race_tick", int'(tick), 1);
        chk("race_stall", int'(stall), 0);
        chk("race_locked", int'(locked), 1);
        chk("race_period", int'(period), 16);
        cyc(1);
        chk("race_after_stall", int'(stall), 0);
        chk("race_after_locked", int'(locked), 1);

        // One-cycle reset mid-lock with clk_in high
        do_reset();
        clk_in = 1'b1;
        cyc(4);
        clk_in = 1'b0;
        cyc(4);
        clk_in = 1'b1;
        cyc(3);
        chk("mid_pre_period", int'(period), 8);
        rst = 1'b0;
        cyc(1);
        chk_all("mid_rst", 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        cyc(2);
        chk("mid_rel_tick2", int'(tick), 0);
        chk("mid_rel_locked2", int'(locked), 0);
        chk("mid_rel_stall2", int'(stall), 0);
        cyc(1);
        chk("mid_rel_tick3", int'(tick), 1);
        nt = 0;
        for (int c = 0; c < 6; c++) begin
            cyc(1);
            if (tick) nt++;
        end
        chk("mid_no_extra_tick", nt, 0);

        // en low: counters hold, ticks still produced
        do_reset();
        clk_in = 1'b1;
        cyc(3);
        en = 1'b0;
        ns = 0;
        for (int c = 0; c < 20; c++) begin
            cyc(1);
            if (stall) ns++;
        end
        chk("en_no_stall", ns, 0);
        chk("en_locked", int'(locked), 1);
        chk("en_ecnt_hold", int'(edge_cnt), 1);
        clk_in = 1'b0;
        cyc(4);
        clk_in = 1'b1;
        cyc(2);
        chk("en_pre_tick", int'(tick), 0);
        cyc(1);
        chk("en_tick", int'(tick), 1);
        chk("en_ecnt_after_tick", int'(edge_cnt), 1);
        chk("en_stall_after", int'(stall), 0);
        en = 1'b1;
        cyc(15);
        chk("en_resume15", int'(stall), 0);
        cyc(1);
        chk("en_resume16", int'(stall), 1);

        // edge_cnt wrap from 0xFFFF
        do_reset();
        force dut.edge_cnt = 16'hFFFF;
        #1;
        release dut.edge_cnt;
        chk("wrap_preload", int'(edge_cnt), 16'hFFFF);
        clk_in = 1'b1;
        cyc(3);
        chk("wrap_tick", int'(tick), 1);
        chk("wrap_ecnt", int'(edge_cnt), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
